imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of the encoded-instruction counter.
REQ-002 The block SHALL have parameter ERR_W, default 8, meaning the width of the saturating error counter.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 Port in_valid  input  1  means the request fields are valid.
REQ-006 Port in_ready  output  1  means the block accepts a request this cycle.
REQ-007 Port ImmSrc  input  3  selects the immediate format: 000 I, 001 S, 010 B, 011 J, 100 U, others invalid.
REQ-008 Port Imm  input  32  is the full sign-extended immediate to pack.
REQ-009 Port BaseInstr  input  32  holds the instruction with opcode/rd/rs1/rs2/funct fields; its immediate bit positions are don't-care.
REQ-010 Port out_valid  output  1  means InstrOut/ImmErr are valid.
REQ-011 Port out_ready  input  1  means downstream accepts the output this cycle.
REQ-012 Port InstrOut  output  32  is the encoded instruction word.
REQ-013 Port ImmErr  output  1  flags that Imm was not representable in the selected format.
REQ-014 Port EncCount  output  CNT_W  counts completed output handshakes.
REQ-015 Port ErrCount  output  ERR_W  counts completed output handshakes with ImmErr=1.

Function
REQ-016 The block SHALL be a 2-stage pipeline: S1 registers the request; S2 holds the packed result driving the outputs.
REQ-017 Latency SHALL be exactly 2 cycles from the input handshake to out_valid with no backpressure; throughput SHALL be 1 per cycle.
REQ-018 S2 SHALL load when it is empty or out_ready=1; S1 SHALL advance into S2 under the same condition.
REQ-019 in_ready SHALL equal (S1 empty) OR (S1 advancing) and SHALL NOT depend combinationally on in_valid.
REQ-020 While out_valid=1 and out_ready=0, InstrOut, ImmErr and out_valid SHALL hold stable.
REQ-021 I format: InstrOut[31:20] SHALL be Imm[11:0], with all other bits from BaseInstr.
REQ-022 S format: InstrOut[31:25] SHALL be Imm[11:5] and InstrOut[11:7] SHALL be Imm[4:0].
REQ-023 B format: InstrOut[31]=Imm[12], [7]=Imm[11], [30:25]=Imm[10:5], [11:8]=Imm[4:1].
REQ-024 J format: InstrOut[31]=Imm[20], [19:12]=Imm[19:12], [20]=Imm[11], [30:21]=Imm[10:1].
REQ-025 U format: InstrOut[31:12] SHALL be Imm[31:12].
REQ-026 For an invalid ImmSrc, InstrOut SHALL equal BaseInstr and ImmErr SHALL be 1.
REQ-027 ImmErr SHALL be 1 in these cases: I/S when Imm[31:11] is not all-equal; B when Imm[31:12] is not all-equal or Imm[0]=1; J when Imm[31:20] is not all-equal or Imm[0]=1; U when Imm[11:0]≠0.
REQ-028 An erroneous request SHALL still be emitted, with truncated fields per REQ-021..025.
REQ-029 EncCount SHALL increment by 1 on each out_valid&out_ready cycle and wrap modulo 2^CNT_W.
REQ-030 ErrCount SHALL increment on the same handshake when ImmErr=1 and saturate at all-ones.
REQ-031 Re-decoding InstrOut with the team's immediate extend unit, using the same ImmSrc, SHALL return Imm whenever ImmErr=0.

Reset
REQ-032 When rst_n=0 at a clock edge, both stage valids, out_valid, ImmErr, InstrOut, EncCount and ErrCount SHALL become 0.
REQ-033 While rst_n=0, in_ready SHALL be 0; after reset it SHALL be 1 in the first cycle with rst_n=1.
REQ-034 A reset mid-operation SHALL discard in-flight requests without emitting them.

Structure
REQ-035 The ImmSrc encodings (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U) SHALL live in the shared riscv_pkg, which the immediate extend unit also uses.
REQ-036 Field scatter and range check SHALL be one combinational sub-module, imm_pack, instantiated between S1 and S2.

Verification
REQ-037 Directed scenario: I, Imm=0xFFFFF800, Base=0x00000013 -> InstrOut=0x80000013, ImmErr=0, 2 cycles later.
REQ-038 Directed scenario: B, Imm=0x00000FFE, Base=0x00000063 -> InstrOut=0x7E000FE3, ImmErr=0; Imm=0x00000003 -> ImmErr=1.
REQ-039 Directed scenario: U, Imm=0x12345001 -> ImmErr=1, InstrOut[31:12]=0x12345, ErrCount=1.
REQ-040 Directed scenario: back-to-back requests with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted, outputs stable, no loss or duplication.
REQ-041 Directed scenario: assert rst_n=0 with both stages full -> next cycle out_valid=0, EncCount=0, and no stale output after release.
REQ-042 Directed scenario: random legal (ImmSrc, Imm) round-trip through the immediate extend unit -> equality on every sample; EncCount wraps 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RISC-V definitions. Holds the immediate-format
//                selector encodings used by both the immediate extend unit
//                and the immediate encoder, plus the S1 request record and a
//                small range-check helper.
//  Contents    : immSrc_e        - ImmSrc encodings (IMM_I .. IMM_U)
//                immReq_t        - registered request (selector, imm, base)
//                c_signMask*     - upper-bit masks that must be uniform
//                signExtOk()     - masked bits all-zero or all-one
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int unsigned c_xlen = 32;

    // 3'b101..3'b111 are unused encodings and are treated as invalid.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immSrc_e;

    typedef struct packed {
        logic [2:0]        immSrc;
        logic [c_xlen-1:0] imm;
        logic [c_xlen-1:0] baseInstr;
    } immReq_t;

    // Bits above the highest encoded immediate bit; they must all replicate
    // the sign for the value to be representable in that format.
    localparam logic [c_xlen-1:0] c_signMaskIS = 32'hFFFF_F800; // [31:11]
    localparam logic [c_xlen-1:0] c_signMaskB  = 32'hFFFF_F000; // [31:12]
    localparam logic [c_xlen-1:0] c_signMaskJ  = 32'hFFF0_0000; // [31:20]

    function automatic logic signExtOk(input logic [c_xlen-1:0] value,
                                       input logic [c_xlen-1:0] mask);
        return ((value & mask) == mask) || ((value & mask) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pack
//  Description : Combinational immediate scatter and range check. Places the
//                immediate bits of the selected format into the base
//                instruction and flags values the format cannot represent.
//                Out-of-range values are still scattered (truncated).
//  Ports       : i_immSrc    in  3   format selector (riscv_pkg encodings)
//                i_imm       in  32  sign-extended immediate
//                i_baseInstr in  32  instruction with non-immediate fields
//                o_instr     out 32  packed instruction
//                o_immErr    out 1   immediate not representable
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_pack
    import riscv_pkg::*;
(
    input  logic [2:0]        i_immSrc,
    input  logic [c_xlen-1:0] i_imm,
    input  logic [c_xlen-1:0] i_baseInstr,
    output logic [c_xlen-1:0] o_instr,
    output logic              o_immErr
);

    logic [c_xlen-1:0] w_instr;
    logic              w_err;

    always_comb begin
        w_instr = i_baseInstr;
        w_err   = 1'b0;
        case (i_immSrc)
            IMM_I: begin
                w_instr[31:20] = i_imm[11:0];
                w_err          = !signExtOk(i_imm, c_signMaskIS);
            end
            IMM_S: begin
                w_instr[31:25] = i_imm[11:5];
                w_instr[11:7]  = i_imm[4:0];
                w_err          = !signExtOk(i_imm, c_signMaskIS);
            end
            IMM_B: begin
                // Branch offsets are halfword aligned; bit 0 is not encoded.
                w_instr[31]    = i_imm[12];
                w_instr[30:25] = i_imm[10:5];
                w_instr[11:8]  = i_imm[4:1];
                w_instr[7]     = i_imm[11];
                w_err          = !signExtOk(i_imm, c_signMaskB) || i_imm[0];
            end
            IMM_J: begin
                w_instr[31]    = i_imm[20];
                w_instr[30:21] = i_imm[10:1];
                w_instr[20]    = i_imm[11];
                w_instr[19:12] = i_imm[19:12];
                w_err          = !signExtOk(i_imm, c_signMaskJ) || i_imm[0];
            end
            IMM_U: begin
                w_instr[31:12] = i_imm[31:12];
                w_err          = |i_imm[11:0];
            end
            default: begin
                // Unknown format: pass the base through untouched.
                w_err = 1'b1;
            end
        endcase
    end

    assign o_instr  = w_instr;
    assign o_immErr = w_err;

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : Two-stage valid/ready immediate encoder. S1 registers the
//                request, imm_pack scatters/checks it, S2 holds the result
//                on the outputs. Counts output handshakes (wrapping) and
//                erroneous handshakes (saturating).
//  Parameters  : CNT_W - width of EncCount
//                ERR_W - width of ErrCount
//  Ports       : clk        in   1      clock, rising edge
//                rst_n      in   1      synchronous active-low reset
//                in_valid   in   1      request valid
//                in_ready   out  1      request accepted this cycle
//                ImmSrc     in   3      immediate format selector
//                Imm        in   32     sign-extended immediate
//                BaseInstr  in   32     instruction template
//                out_valid  out  1      InstrOut/ImmErr valid
//                out_ready  in   1      downstream accepts output
//                InstrOut   out  32     encoded instruction
//                ImmErr     out  1      immediate not representable
//                EncCount   out  CNT_W  completed output handshakes
//                ErrCount   out  ERR_W  completed handshakes with ImmErr=1
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ImmSrc,
    input  logic [c_xlen-1:0] Imm,
    input  logic [c_xlen-1:0] BaseInstr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [c_xlen-1:0] InstrOut,
    output logic              ImmErr,
    output logic [CNT_W-1:0]  EncCount,
    output logic [ERR_W-1:0]  ErrCount
);

    logic              r_s1Valid;
    immReq_t           r_s1Req;
    logic              r_s2Valid;
    logic [c_xlen-1:0] r_s2Instr;
    logic              r_s2Err;
    logic [CNT_W-1:0]  r_encCount;
    logic [ERR_W-1:0]  r_errCount;

    logic              w_s2Load;
    logic              w_s1Load;
    logic              w_outFire;
    logic [c_xlen-1:0] w_packInstr;
    logic              w_packErr;

    // S2 can take new data when empty or when its content leaves this cycle;
    // S1 frees up under the same condition, so in_ready only looks at state.
    assign w_s2Load  = !r_s2Valid || out_ready;
    assign w_s1Load  = !r_s1Valid || w_s2Load;
    assign w_outFire = r_s2Valid && out_ready;
    assign in_ready  = rst_n && w_s1Load;

    imm_pack u_pack (
        .i_immSrc    (r_s1Req.immSrc),
        .i_imm       (r_s1Req.imm),
        .i_baseInstr (r_s1Req.baseInstr),
        .o_instr     (w_packInstr),
        .o_immErr    (w_packErr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid  <= 1'b0;
            r_s1Req    <= '0;
            r_s2Valid  <= 1'b0;
            r_s2Instr  <= '0;
            r_s2Err    <= 1'b0;
            r_encCount <= '0;
            r_errCount <= '0;
        end else begin
            if (w_s1Load) begin
                r_s1Valid <= in_valid;
                if (in_valid) begin
                    r_s1Req <= '{immSrc: ImmSrc, imm: Imm, baseInstr: BaseInstr};
                end
            end
            if (w_s2Load) begin
                r_s2Valid <= r_s1Valid;
                if (r_s1Valid) begin
                    r_s2Instr <= w_packInstr;
                    r_s2Err   <= w_packErr;
                end
            end
            if (w_outFire) begin
                r_encCount <= r_encCount + CNT_W'(1);
                if (r_s2Err && !(&r_errCount)) begin
                    r_errCount <= r_errCount + ERR_W'(1);
                end
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign InstrOut  = r_s2Instr;
    assign ImmErr    = r_s2Err;
    assign EncCount  = r_encCount;
    assign ErrCount  = r_errCount;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Self-checking bench for imm_encoder. Directed vector table,
//                backpressure and reset sequences, error-count saturation and
//                a randomized run against a bit-mapping reference model with
//                a round-trip decode. A second instance with narrow counters
//                shares the stimulus to exercise counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

    localparam logic [2:0] SRC_I = 3'd0;
    localparam logic [2:0] SRC_S = 3'd1;
    localparam logic [2:0] SRC_B = 3'd2;
    localparam logic [2:0] SRC_J = 3'd3;
    localparam logic [2:0] SRC_U = 3'd4;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic [2:0]  immSrc = 3'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] baseInstr = 32'd0;

    logic        inReady, outValid, immErr;
    logic [31:0] instrOut;
    logic [15:0] encCount;
    logic [7:0]  errCount;

    logic        inReadyS, outValidS, immErrS;
    logic [31:0] instrOutS;
    logic [3:0]  encCountS;
    logic [1:0]  errCountS;

    imm_encoder dut (
        .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
        .ImmSrc(immSrc), .Imm(imm), .BaseInstr(baseInstr),
        .out_valid(outValid), .out_ready(outReady), .InstrOut(instrOut),
        .ImmErr(immErr), .EncCount(encCount), .ErrCount(errCount)
    );

    imm_encoder #(.CNT_W(4), .ERR_W(2)) dutSmall (
        .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReadyS),
        .ImmSrc(immSrc), .Imm(imm), .BaseInstr(baseInstr),
        .out_valid(outValidS), .out_ready(outReady), .InstrOut(instrOutS),
        .ImmErr(immErrS), .EncCount(encCountS), .ErrCount(errCountS)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Which immediate bit lands on instruction bit i (-1: taken from base).
    function automatic int srcBit(input logic [2:0] src, input int i);
        case (src)
            SRC_I: return (i >= 20) ? i - 20 : -1;
            SRC_S: begin
                if (i >= 25) return i - 20;
                if (i >= 7 && i <= 11) return i - 7;
                return -1;
            end
            SRC_B: begin
                if (i == 31) return 12;
                if (i == 7) return 11;
                if (i >= 25) return i - 20;
                if (i >= 8 && i <= 11) return i - 7;
                return -1;
            end
            SRC_J: begin
                if (i == 31) return 20;
                if (i == 20) return 11;
                if (i >= 21) return i - 20;
                if (i >= 12 && i <= 19) return i;
                return -1;
            end
            SRC_U: return (i >= 12) ? i : -1;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] modelInstr(input logic [2:0] src, input logic [31:0] im,
                                               input logic [31:0] base);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            int k;
            k = srcBit(src, i);
            r[i] = (k < 0) ? base[i] : im[k];
        end
        return r;
    endfunction

    function automatic logic modelErr(input logic [2:0] src, input logic [31:0] im);
        longint v;
        v = $signed(im);
        case (src)
            SRC_I, SRC_S: return (v < -2048) || (v > 2047);
            SRC_B:        return (v < -4096) || (v > 4095) || im[0];
            SRC_J:        return (v < -1048576) || (v > 1048575) || im[0];
            SRC_U:        return (im % 32'd4096) != 32'd0;
            default:      return 1'b1;
        endcase
    endfunction

    // Independent immediate extend: gather bits back and sign-extend.
    function automatic logic [31:0] decode(input logic [2:0] src, input logic [31:0] ins);
        logic [31:0] r;
        int msb;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            int k;
            k = srcBit(src, i);
            if (k >= 0) r[k] = ins[i];
        end
        case (src)
            SRC_I, SRC_S: msb = 11;
            SRC_B:        msb = 12;
            SRC_J:        msb = 20;
            default:      msb = 31;
        endcase
        for (int j = msb + 1; j < 32; j++) r[j] = r[msb];
        return r;
    endfunction

    // ---------------- scoreboard monitor ----------------
    typedef struct {
        logic [2:0]  src;
        logic [31:0] im;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic        monOn = 1'b0;
    int          encTotal = 0;
    int          errTotal = 0;
    logic        prevHold = 1'b0;
    logic [31:0] prevInstr = 32'd0;
    logic        prevErr = 1'b0;

    always @(negedge clk) begin
        if (monOn) begin
            check("encCount", 32'(encCount), 32'(encTotal % 65536));
            check("errCount", 32'(errCount), 32'((errTotal > 255) ? 255 : errTotal));
            check("encCountSmall", 32'(encCountS), 32'(encTotal % 16));
            check("errCountSmall", 32'(errCountS), 32'((errTotal > 3) ? 3 : errTotal));
            if (prevHold) begin
                check("holdValid", 32'(outValid), 32'd1);
                check("holdInstr", instrOut, prevInstr);
                check("holdErr", 32'(immErr), 32'(prevErr));
            end
            prevHold = 1'b0;
            if (!rstN) begin
                check("rstInReady", 32'(inReady), 32'd0);
                sbq.delete();
                encTotal = 0;
                errTotal = 0;
            end else begin
                if (outValid && outReady) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpectedOutput: got instr %h with nothing outstanding", instrOut);
                    end else begin
                        e = sbq.pop_front();
                        check("instr", instrOut, e.instr);
                        check("err", 32'(immErr), 32'(e.err));
                        check("instrSmall", instrOutS, e.instr);
                        if (!e.err) check("roundTrip", decode(e.src, instrOut), e.im);
                        encTotal++;
                        if (e.err) errTotal++;
                    end
                end
                if (outValid && !outReady) begin
                    prevHold  = 1'b1;
                    prevInstr = instrOut;
                    prevErr   = immErr;
                end
                if (inValid && inReady) begin
                    sbq.push_back('{immSrc, imm, modelInstr(immSrc, imm, baseInstr),
                                    modelErr(immSrc, imm)});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic genRandom(output logic [2:0] src, output logic [31:0] im);
        int r;
        r = $urandom_range(0, 5);
        src = (r == 5) ? 3'($urandom_range(5, 7)) : 3'(r);
        if ($urandom_range(0, 3) == 0) begin
            im = $urandom;
        end else begin
            case (src)
                SRC_I, SRC_S: im = 32'($urandom_range(0, 4095)) - 32'd2048;
                SRC_B:        im = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
                SRC_J:        im = (32'($urandom_range(0, 1048575)) - 32'h8_0000) << 1;
                SRC_U:        im = $urandom & 32'hFFFF_F000;
                default:      im = $urandom;
            endcase
        end
    endtask

    task automatic presentRandom();
        logic [2:0]  s;
        logic [31:0] v;
        genRandom(s, v);
        inValid   = 1'b1;
        immSrc    = s;
        imm       = v;
        baseInstr = $urandom;
    endtask

    typedef struct {
        logic [2:0]  src;
        logic [31:0] im;
        logic [31:0] base;
        logic [31:0] expInstr;
        logic        expErr;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   n;
        vecs[0]  = '{SRC_I, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0};
        vecs[1]  = '{SRC_B, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0};
        vecs[2]  = '{SRC_B, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1};
        vecs[3]  = '{SRC_U, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1};
        vecs[4]  = '{SRC_S, 32'hFFFF_FFFF, 32'h0000_2023, 32'hFE00_2FA3, 1'b0};
        vecs[5]  = '{SRC_J, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0};
        vecs[6]  = '{SRC_J, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1};
        vecs[7]  = '{3'b101, 32'h0000_0005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[8]  = '{SRC_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
        vecs[9]  = '{SRC_U, 32'hFFFF_F000, 32'hABCD_E0B7, 32'hFFFF_F0B7, 1'b0};
        vecs[10] = '{SRC_I, 32'h0000_07FF, 32'hFFF0_0093, 32'h7FF0_0093, 1'b0};
        vecs[11] = '{SRC_S, 32'hFFFF_F7FF, 32'h0000_0023, 32'h7E00_0FA3, 1'b1};

        // Reset state
        repeat (3) tick();
        monOn = 1'b1;
        @(negedge clk);
        check("rstOutValid", 32'(outValid), 32'd0);
        check("rstInstr", instrOut, 32'd0);
        check("rstImmErr", 32'(immErr), 32'd0);
        check("rstInReady", 32'(inReady), 32'd0);
        tick();
        rstN = 1'b1;
        @(negedge clk);
        check("firstReady", 32'(inReady), 32'd1);

        // Directed vectors, one at a time, with latency check
        outReady = 1'b1;
        foreach (vecs[k]) begin
            tick();
            inValid = 1'b1; immSrc = vecs[k].src; imm = vecs[k].im; baseInstr = vecs[k].base;
            tick();
            inValid = 1'b0;
            @(negedge clk);
            check($sformatf("latEarly%0d", k), 32'(outValid), 32'd0);
            tick();
            @(negedge clk);
            check($sformatf("latValid%0d", k), 32'(outValid), 32'd1);
            check($sformatf("vecInstr%0d", k), instrOut, vecs[k].expInstr);
            check($sformatf("vecErr%0d", k), 32'(immErr), 32'(vecs[k].expErr));
        end

        // Backpressure: three requests, out_ready low for three cycles
        tick();
        outReady = 1'b0;
        presentRandom();
        @(negedge clk); check("bpReady0", 32'(inReady), 32'd1);
        tick(); presentRandom();
        @(negedge clk); check("bpReady1", 32'(inReady), 32'd1);
        tick(); presentRandom();
        @(negedge clk); check("bpReady2", 32'(inReady), 32'd0);
        tick(); outReady = 1'b1;
        @(negedge clk); check("bpReady3", 32'(inReady), 32'd1);
        tick(); inValid = 1'b0;
        repeat (4) tick();
        check("bpDrain", 32'(sbq.size()), 32'd0);

        // Reset with both stages full
        outReady = 1'b0;
        presentRandom();
        tick(); presentRandom();
        tick(); inValid = 1'b0;
        @(negedge clk); check("fullBeforeRst", 32'(outValid), 32'd1);
        tick(); rstN = 1'b0;
        tick();
        @(negedge clk);
        check("midRstOutValid", 32'(outValid), 32'd0);
        check("midRstEnc", 32'(encCount), 32'd0);
        check("midRstErrCnt", 32'(errCount), 32'd0);
        tick(); rstN = 1'b1; outReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); check("noStale", 32'(outValid), 32'd0);
            tick();
        end

        // Error counter saturation
        for (int c = 0; c < 300; c++) begin
            inValid = 1'b1; immSrc = 3'd6; imm = $urandom; baseInstr = $urandom;
            tick();
        end
        inValid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("errSat", 32'(errCount), 32'd255);
        check("errSatSmall", 32'(errCountS), 32'd3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 99) < 70) presentRandom();
            else inValid = 1'b0;
            outReady = ($urandom_range(0, 99) < 70);
        end
        tick();
        inValid = 1'b0;
        outReady = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("finalDrain", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
